teclado_matriz_fifo: RTL

Parametrised matrix-keypad scanner and decoder, the successor to the fixed 4x4 keypad decoder. It scans an N_LIN x N_COL matrix, debounces both press and release, and encodes the key as a row-major index. Optional typematic auto-repeat is supported. Decoded keys are buffered in a small FIFO and drained through a valid/ready handshake. The block sits between the board keypad pins and any consumer logic, such as the display or command FSM.

---
 rtl/teclado_matriz_fifo_pkg.sv | 25 ++
 rtl/teclado_matriz_fifo_if.sv | 33 +++
 rtl/teclado_matriz_fifo_fifo.sv | 64 ++++++
 rtl/teclado_matriz_fifo.sv | 138 +++++++++++++
 4 files changed

// File: rtl/teclado_matriz_fifo_pkg.sv
// Purpose: shared types and defaults for the keypad scanner/decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scan FSM state enum, key-code width helper, default parameter values.
package teclado_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  localparam int DEF_N_LIN      = 4;
  localparam int DEF_N_COL      = 4;
  localparam int DEF_DEBOUNCE_P = 5;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_REPEAT_P   = 0;

  // Bits needed for a row-major key index; never narrower than one bit.
  function automatic int key_width(input int n_lin, input int n_col);
    return (n_lin * n_col > 1) ? $clog2(n_lin * n_col) : 1;
  endfunction

endpackage

// File: rtl/teclado_matriz_fifo_if.sv
// Purpose: bundles the keypad matrix pins and the decoded-key handshake.
// Latency: n/a (wiring only).
// Backpressure: tecla_ready from the consumer; pop when tecla_valid && tecla_ready.
// master = keypad block (drives rows, key stream); slave = board/consumer side.
interface teclado_matriz_fifo_if #(
  parameter int N_LIN      = 4,
  parameter int N_COL      = 4,
  parameter int FIFO_DEPTH = 4
);
  import teclado_pkg::*;

  localparam int KW = key_width(N_LIN, N_COL);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N_COL-1:0] col_matriz;   // column sense, active-low
  logic [N_LIN-1:0] lin_matriz;   // row drive, one-cold
  logic [KW-1:0]    tecla_value;  // key code at FIFO head
  logic             tecla_valid;  // FIFO not empty
  logic             tecla_ready;  // consumer accepts head
  logic [CW-1:0]    fifo_count;   // stored entries
  logic             overflow;     // one-cycle pulse on a dropped key

  modport master (
    input  col_matriz, tecla_ready,
    output lin_matriz, tecla_value, tecla_valid, fifo_count, overflow
  );

  modport slave (
    output col_matriz, tecla_ready,
    input  lin_matriz, tecla_value, tecla_valid, fifo_count, overflow
  );

endinterface

// File: rtl/teclado_matriz_fifo_fifo.sv
// Purpose: small synchronous FIFO for decoded key codes.
// Latency: push visible at head one cycle after the push edge into an empty FIFO.
// Backpressure: push while full (without a pop) is dropped and flagged on o_drop.
// Ports: clk, rst (sync, active-high), i_push/i_push_dat, i_pop, o_head_dat,
//        o_empty, o_count, o_drop (registered one-cycle pulse).
module teclado_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             r_drop;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (AW+1)'(1);
      r_drop <= i_push && !w_push;
    end
  end

  // Head reads as 0 when empty so the output is defined out of reset.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd];
  assign o_count    = r_cnt;
  assign o_drop     = r_drop;

endmodule

// File: rtl/teclado_matriz_fifo.sv
// Purpose: scans an N_LIN x N_COL keypad, debounces press/release, optional auto-repeat, buffers codes.
// Latency: code pushed DEBOUNCE_P edges after capture, visible at the head one cycle later.
// Backpressure: tecla_ready pops the head; a key arriving while full is dropped with an overflow pulse.
// Ports: clk, rst (sync, active-high), io_kp (master modport: col_matriz in, lin_matriz out,
//        tecla_value/valid/ready stream, fifo_count, overflow).
module teclado_matriz_fifo
  import teclado_pkg::*;
#(
  parameter int N_LIN      = DEF_N_LIN,
  parameter int N_COL      = DEF_N_COL,
  parameter int DEBOUNCE_P = DEF_DEBOUNCE_P,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REPEAT_P   = DEF_REPEAT_P
) (
  input  logic                   clk,
  input  logic                   rst,
  teclado_matriz_fifo_if.master  io_kp
);
  localparam int KW  = key_width(N_LIN, N_COL);
  localparam int RW  = $clog2(N_LIN);
  localparam int CLW = $clog2(N_COL);
  localparam int DW  = $clog2(DEBOUNCE_P + 1);
  localparam int RPW = (REPEAT_P > 0) ? $clog2(REPEAT_P + 1) : 1;

  state_t         r_state;
  logic [RW-1:0]  r_row;   // doubles as the captured row while not scanning
  logic [CLW-1:0] r_col;
  logic [DW-1:0]  r_deb;
  logic [RPW-1:0] r_rep;

  logic [CLW-1:0] w_hit_col;
  logic           w_any;
  logic           w_closed;
  logic           w_push;
  logic [KW-1:0]  w_code;
  logic [RW-1:0]  w_row_next;

  // Lowest-index closed column wins when several are low.
  always_comb begin
    w_hit_col = '0;
    w_any     = 1'b0;
    for (int i = N_COL - 1; i >= 0; i--) begin
      if (!io_kp.col_matriz[i]) begin
        w_hit_col = CLW'(i);
        w_any     = 1'b1;
      end
    end
  end

  assign w_closed   = !io_kp.col_matriz[r_col];
  assign w_row_next = (r_row == RW'(N_LIN - 1)) ? '0 : r_row + RW'(1);
  assign w_code     = KW'(int'(r_row) * N_COL + int'(r_col));

  // Push is combinational so the FIFO captures the code on the same edge the FSM decides.
  always_comb begin
    w_push = 1'b0;
    unique case (r_state)
      DEB_PRESS: w_push = w_closed && (r_deb == DW'(DEBOUNCE_P - 1));
      PRESSED:   w_push = (REPEAT_P > 0) && w_closed && (r_rep == RPW'(REPEAT_P - 1));
      default:   w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN;
      r_row   <= '0;
      r_col   <= '0;
      r_deb   <= '0;
      r_rep   <= '0;
    end else begin
      unique case (r_state)
        SCAN: begin
          if (w_any) begin
            r_col   <= w_hit_col;
            r_deb   <= '0;
            r_state <= DEB_PRESS;
          end else begin
            r_row <= w_row_next;
          end
        end
        DEB_PRESS: begin
          if (!w_closed) begin
            r_state <= SCAN;
            r_row   <= w_row_next;
          end else if (r_deb == DW'(DEBOUNCE_P - 1)) begin
            r_state <= PRESSED;
            r_rep   <= '0;
          end else begin
            r_deb <= r_deb + DW'(1);
          end
        end
        PRESSED: begin
          if (!w_closed) begin
            r_state <= DEB_REL;
            r_deb   <= '0;
          end else if (REPEAT_P > 0) begin
            r_rep <= w_push ? '0 : r_rep + RPW'(1);
          end
        end
        DEB_REL: begin
          if (w_closed) begin
            // Bounce during release: key still held, repeat period restarts.
            r_state <= PRESSED;
            r_rep   <= '0;
          end else if (r_deb == DW'(DEBOUNCE_P - 1)) begin
            r_state <= SCAN;
            r_row   <= '0;
          end else begin
            r_deb <= r_deb + DW'(1);
          end
        end
      endcase
    end
  end

  assign io_kp.lin_matriz = ~(N_LIN'(1) << r_row);

  logic w_empty;

  teclado_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_code),
    .i_pop      (io_kp.tecla_ready),
    .o_head_dat (io_kp.tecla_value),
    .o_empty    (w_empty),
    .o_count    (io_kp.fifo_count),
    .o_drop     (io_kp.overflow)
  );

  assign io_kp.tecla_valid = !w_empty;

endmodule
